// File: rtl/mem64x8_wb_bridge.sv
// mem64x8_wb_bridge
//   Wishbone slave front-end for the 64x8 byte memory array. Each 32-bit
//   access is split into four sequential byte slots (lane 0..3) on the
//   array's single-port interface. Read bytes are gathered back into a word
//   and returned with a one-cycle ack. Latency does not depend on sel.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for cyc & stb & address hit
//   ACCESS | one cycle per lane; strobe memory when that lane is selected
//   DRAIN  | read only: collect the byte returned for lane 3
//   ACK    | wbs_ack_o high for exactly one cycle
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-low reset
//   wbs_cyc_i .. wbs_dat_i      Wishbone slave request inputs
//   wbs_ack_o, wbs_dat_o        Wishbone response (registered)
//   mem_en, mem_we, mem_addr,
//   mem_wdata                   byte-array request (registered)
//   mem_rdata                   byte-array read data, one cycle after issue
//   busy                        high whenever the FSM is not in IDLE
module mem64x8_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFC0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        mem_en,
  output logic        mem_we,
  output logic [5:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, ACK} state_t;

  state_t      state, state_n;
  logic [1:0]  lane, lane_n, lane_inc, lane_prv;
  logic [3:0]  word_q, word_n;
  logic        we_q, we_n;
  logic [3:0]  sel_q, sel_n;
  logic [31:0] dat_q, dat_n;
  logic [31:0] rbuf, rbuf_n;
  logic        ack_n;
  logic [31:0] dat_o_n;
  logic        en_n, mwe_n;
  logic [5:0]  addr_n;
  logic [7:0]  wdata_n;
  logic        req;
  logic [7:0]  rbyte;

  assign req      = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign lane_inc = lane + 2'd1;
  assign lane_prv = lane - 2'd1;
  // Data arriving now belongs to the lane issued one cycle earlier. lane wraps
  // to 0 on entry to DRAIN, so lane_prv is 3 there.
  assign rbyte    = sel_q[lane_prv] ? mem_rdata : 8'h00;

  always_comb begin
    state_n = state;
    lane_n  = lane;
    word_n  = word_q;
    we_n    = we_q;
    sel_n   = sel_q;
    dat_n   = dat_q;
    rbuf_n  = rbuf;
    ack_n   = 1'b0;
    dat_o_n = wbs_dat_o;
    en_n    = 1'b0;
    mwe_n   = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    case (state)
      IDLE: begin
        if (req) begin
          word_n  = wbs_adr_i[5:2];
          we_n    = wbs_we_i;
          sel_n   = wbs_sel_i;
          dat_n   = wbs_dat_i;
          rbuf_n  = 32'h0;
          lane_n  = 2'd0;
          // Lane 0 is set up here so the registered strobe lands in the
          // first ACCESS cycle.
          en_n    = wbs_sel_i[0];
          mwe_n   = wbs_we_i & wbs_sel_i[0];
          addr_n  = {wbs_adr_i[5:2], 2'd0};
          wdata_n = wbs_dat_i[7:0];
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (!wbs_cyc_i) begin
          lane_n  = 2'd0;
          state_n = IDLE;
        end else begin
          lane_n = lane_inc;
          if (!we_q && lane != 2'd0)
            rbuf_n[{lane_prv, 3'b000} +: 8] = rbyte;
          if (lane == 2'd3) begin
            if (we_q) begin
              ack_n   = 1'b1;
              dat_o_n = 32'h0;
              state_n = ACK;
            end else begin
              state_n = DRAIN;
            end
          end else begin
            en_n    = sel_q[lane_inc];
            mwe_n   = we_q & sel_q[lane_inc];
            addr_n  = {word_q, lane_inc};
            wdata_n = dat_q[{lane_inc, 3'b000} +: 8];
          end
        end
      end
      DRAIN: begin
        if (!wbs_cyc_i) begin
          state_n = IDLE;
        end else begin
          rbuf_n[31:24] = rbyte;
          ack_n         = 1'b1;
          dat_o_n       = {rbyte, rbuf[23:0]};
          state_n       = ACK;
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state     <= IDLE;
      lane      <= 2'd0;
      word_q    <= 4'h0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      dat_q     <= 32'h0;
      rbuf      <= 32'h0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 6'h0;
      mem_wdata <= 8'h0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      lane      <= lane_n;
      word_q    <= word_n;
      we_q      <= we_n;
      sel_q     <= sel_n;
      dat_q     <= dat_n;
      rbuf      <= rbuf_n;
      wbs_ack_o <= ack_n;
      wbs_dat_o <= dat_o_n;
      mem_en    <= en_n;
      mem_we    <= mwe_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: doc/mem64x8_wb_bridge.md
Name: mem64x8_wb_bridge

Overview:
- Wishbone slave front-end for the 64x8 byte memory array inside the user project.
- Translates each 32-bit Wishbone access into up to four sequential byte accesses on the array's single-port interface.
- For reads, reassembles the returned bytes into a word and returns it on wbs_dat_o with a one-cycle wbs_ack_o.
- Sits between the management SoC Wishbone port in user_project_wrapper and the memory array.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte base address of the 64-byte memory window.
- ADDR_MASK, 32'hFFFF_FFC0, hit when (wbs_adr_i & ADDR_MASK) == BASE_ADDR.

Ports:
- wb_clk_i  input  1  sole clock, all logic on rising edge.
- wb_rst_i  input  1  reset, synchronous, active-low (0 = reset).
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_we_i  input  1  1 = write.
- wbs_sel_i  input  4  byte-lane enables, lane n = bits [8n+7:8n].
- wbs_adr_i  input  32  byte address; bits [5:2] = word index.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  one-cycle acknowledge.
- wbs_dat_o  output  32  read data.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable, valid with mem_en.
- mem_addr  output  6  byte address = {word index, lane}.
- mem_wdata  output  8  write byte.
- mem_rdata  input  8  read byte, valid exactly 1 cycle after a mem_en=1, mem_we=0 cycle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (wb_rst_i=0 at a clock edge):
  - State goes to IDLE; the lane counter and all latches clear.
  - wbs_ack_o=0, wbs_dat_o=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
  - Reset mid-transaction aborts it: no ack, remaining lanes are not issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, DRAIN, ACK.
- IDLE:
  - A request is cyc & stb & address hit.
  - On a request at edge T, latch word index = adr[5:2], we, sel, dat; set lane=0; go to ACCESS.
  - Address miss: no response, stay in IDLE.
- ACCESS (4 cycles, lane 0..3, lane increments every cycle):
  - If sel[lane]=1: mem_en=1, mem_we=we, mem_addr={word,lane}, mem_wdata=dat[8*lane+7:8*lane].
  - If sel[lane]=0: mem_en=0 and the lane's read byte = 8'h00.
  - Read capture is pipelined: mem_rdata is stored into byte lane-1 on the cycle after its issue.
  - After lane 3: a write goes to ACK; a read goes to DRAIN.
- DRAIN (read only, 1 cycle): capture byte 3, then go to ACK.
- ACK (1 cycle):
  - wbs_ack_o=1.
  - Read: wbs_dat_o = assembled {b3,b2,b1,b0}.
  - Write: wbs_dat_o = 0.
  - Then go to IDLE. wbs_dat_o holds its value until the next ack.
- Fixed latency, independent of sel:
  - Write: the ACK cycle is the 5th cycle after the accepting edge.
  - Read: the ACK cycle is the 6th cycle after the accepting edge.
- sel=4'b0000: no memory strobes; full latency; ack; read data = 0.
- Back-to-back: a request still asserted during the ACK cycle is not accepted; the earliest acceptance is the cycle after ACK.
- Abort: if cyc_i=0 at any edge in ACCESS or DRAIN, go to IDLE without ack.
  - No further mem_en is issued.
  - Bytes already written remain written.
- Inputs are latched at acceptance. Changes to adr, dat, sel or we during busy are ignored.
- mem_addr wraps only within the 64-byte window: word 15, lane 3 gives address 63.

Test Plan:
- Reset: hold wb_rst_i=0 for 3 cycles with cyc=stb=1 -> no ack, all outputs 0, busy=0; after release the request is accepted the next cycle.
- Full write then read:
  - Write 32'hDEADBEEF to 0x3000_0008, sel=F -> mem writes at addresses 8,9,10,11 with EF,BE,AD,DE; ack 5 cycles after accept.
  - Read the same address -> wbs_dat_o=32'hDEADBEEF; ack 6 cycles after accept.
- Partial lanes:
  - Write 32'h11223344 to 0x3000_003C, sel=4'b1010 -> only addresses 61 (33) and 63 (11) strobed.
  - Read with sel=F -> 32'h11xx33xx, where the untouched bytes keep their earlier contents.
  - Read with sel=4'b0010 -> 32'h0000_3300.
- Miss: access 0x3000_0040 -> no mem_en, no ack, busy stays 0 for 10 cycles.
- Abort: drop cyc after 2 ACCESS cycles of a sel=F write to 0x3000_0000 -> only addresses 0 and 1 written, no ack, busy=0 next cycle, a new request is accepted normally.
- sel=0 read -> no mem_en, ack at the 6th cycle, wbs_dat_o=0.
